// File: rtl/sticky_event_reader.sv
// Sticky event status register with read-and-clear handshake, overrun tracking
// and a maskable interrupt.
module sticky_event_reader (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] evt,
  input  logic [7:0] irq_en,
  input  logic       rd_req,
  output logic       rd_ack,
  output logic [7:0] rd_data,
  output logic [7:0] rd_ovr,
  output logic       irq
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SNAP = 2'd1,
    ACK  = 2'd2,
    WAIT = 2'd3
  } state_t;

  state_t     state_q, state_d;
  logic [7:0] status_q, status_d;
  logic [7:0] ovr_q, ovr_d;
  logic [7:0] rd_data_q, rd_data_d;
  logic [7:0] rd_ovr_q, rd_ovr_d;
  logic       rd_ack_q, rd_ack_d;

  always_comb begin
    state_d   = state_q;
    status_d  = status_q | evt;
    ovr_d     = ovr_q | (evt & status_q);
    rd_data_d = rd_data_q;
    rd_ovr_d  = rd_ovr_q;
    rd_ack_d  = 1'b0;

    unique case (state_q)
      IDLE: if (rd_req) state_d = SNAP;
      SNAP: begin
        // Clear and reload with this cycle's events so a coincident event is kept.
        rd_data_d = status_q;
        rd_ovr_d  = ovr_q;
        status_d  = evt;
        ovr_d     = '0;
        rd_ack_d  = 1'b1;
        state_d   = ACK;
      end
      ACK:  state_d = WAIT;
      WAIT: if (!rd_req) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      status_q  <= '0;
      ovr_q     <= '0;
      rd_data_q <= '0;
      rd_ovr_q  <= '0;
      rd_ack_q  <= 1'b0;
    end else begin
      state_q   <= state_d;
      status_q  <= status_d;
      ovr_q     <= ovr_d;
      rd_data_q <= rd_data_d;
      rd_ovr_q  <= rd_ovr_d;
      rd_ack_q  <= rd_ack_d;
    end
  end

  assign rd_ack  = rd_ack_q;
  assign rd_data = rd_data_q;
  assign rd_ovr  = rd_ovr_q;
  assign irq     = |(status_q & irq_en);

endmodule

// File: tb/tb_sticky_event_reader.sv
// Directed self-checking bench for sticky_event_reader.
module tb_sticky_event_reader;

  logic       clk = 1'b0;
  logic       rst;
  logic [7:0] evt;
  logic [7:0] irq_en;
  logic       rd_req;
  logic       rd_ack;
  logic [7:0] rd_data;
  logic [7:0] rd_ovr;
  logic       irq;

  int unsigned n_checks = 0;
  int unsigned n_fail   = 0;

  sticky_event_reader dut (
    .clk     (clk),
    .rst     (rst),
    .evt     (evt),
    .irq_en  (irq_en),
    .rd_req  (rd_req),
    .rd_ack  (rd_ack),
    .rd_data (rd_data),
    .rd_ovr  (rd_ovr),
    .irq     (irq)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Advance one rising edge; inputs change and outputs are sampled 1ns after it.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Full read from IDLE: expects ack two edges after request, then returns to IDLE.
  task automatic do_read(input string tag, input logic [7:0] exp_data, input logic [7:0] exp_ovr);
    int unsigned n;
    n = 0;
    rd_req = 1'b1;
    while (n < 8) begin
      step();
      n++;
      if (rd_ack) break;
    end
    check({tag, "_latency"}, n, 2);
    rd_req = 1'b0;
    check({tag, "_data"}, rd_data, exp_data);
    check({tag, "_ovr"}, rd_ovr, exp_ovr);
    step();
    check({tag, "_ack_drop"}, rd_ack, 1'b0);
    step();
  endtask

  initial begin
    int unsigned acks;
    int unsigned first_ack;

    rst = 1'b1; evt = '0; irq_en = 8'hFF; rd_req = 1'b0;
    #1;
    step(); step();
    check("rst_ack",  rd_ack,  1'b0);
    check("rst_data", rd_data, 8'h00);
    check("rst_ovr",  rd_ovr,  8'h00);
    check("rst_irq",  irq,     1'b0);
    rst = 1'b0;
    step(); step();
    check("idle_irq", irq, 1'b0);

    // Basic set/read
    evt = 8'h05; step(); evt = '0;
    check("basic_irq_set", irq, 1'b1);
    do_read("basic", 8'h05, 8'h00);
    check("basic_irq_clr", irq, 1'b0);

    // Overrun, then an empty read; read data holds between reads
    evt = 8'h01; step(); evt = '0; step();
    evt = 8'h01; step(); evt = '0;
    do_read("ovr", 8'h01, 8'h01);
    do_read("ovr_empty", 8'h00, 8'h00);
    step(); step(); step();
    check("hold_data", rd_data, 8'h00);

    // Set during clear: event presented exactly in the SNAP cycle
    evt = 8'h02; step(); evt = '0;
    do_read("pre", 8'h02, 8'h00);
    evt = 8'h02; step(); evt = '0;
    rd_req = 1'b1; step();
    evt = 8'h02; step(); evt = '0;
    check("sdc_ack",  rd_ack,  1'b1);
    check("sdc_data", rd_data, 8'h02);
    check("sdc_ovr",  rd_ovr,  8'h00);
    rd_req = 1'b0; step(); step();
    check("sdc_irq", irq, 1'b1);
    do_read("sdc2", 8'h02, 8'h00);

    // Held request: exactly one ack, two edges after first sampling
    acks = 0; first_ack = 0;
    rd_req = 1'b1;
    for (int unsigned i = 1; i <= 10; i++) begin
      step();
      if (rd_ack) begin
        acks++;
        if (first_ack == 0) first_ack = i;
      end
    end
    check("held_acks", acks, 1);
    check("held_first", first_ack, 2);
    check("held_data", rd_data, 8'h00);
    rd_req = 1'b0; step();
    do_read("after_held", 8'h00, 8'h00);

    // irq masking, mask change visible without a clock edge
    irq_en = 8'h7F;
    evt = 8'h80; step(); evt = '0;
    check("mask_irq_off", irq, 1'b0);
    @(negedge clk);
    irq_en = 8'hFF; #1;
    check("mask_irq_on", irq, 1'b1);
    step();
    do_read("mask", 8'h80, 8'h00);
    check("mask_irq_clr", irq, 1'b0);

    // Reset in the SNAP cycle, then a still-high request restarts a read
    evt = 8'hAA; step(); evt = '0;
    check("pre_rst_irq", irq, 1'b1);
    rd_req = 1'b1; step();
    rst = 1'b1; evt = 8'h01; step();
    check("mrst_ack",  rd_ack,  1'b0);
    check("mrst_data", rd_data, 8'h00);
    check("mrst_ovr",  rd_ovr,  8'h00);
    check("mrst_irq",  irq,     1'b0);
    rst = 1'b0; evt = '0;
    step();
    check("mrst_no_ack", rd_ack, 1'b0);
    step();
    check("mrst_new_ack",  rd_ack,  1'b1);
    check("mrst_new_data", rd_data, 8'h00);
    rd_req = 1'b0; step(); step();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout: simulation did not finish, got running expected finished");
    $fatal(1);
  end

endmodule

// File: doc/sticky_event_reader.md
STICKY_EVENT_READER -- requirements
Module: sticky_event_reader

Interface
REQ-001 Parameter: none; event width is fixed at 8 bits.
REQ-002 clk  input  1  Single clock; all state updates on its rising edge.
REQ-003 rst  input  1  Reset, synchronous, active-high; sampled on rising clk.
REQ-004 evt  input  8  Event strobes; bit i high in a cycle reports one event i.
REQ-005 irq_en  input  8  Interrupt enable per status bit; 1 = enabled.
REQ-006 rd_req  input  1  Read-and-clear request, level; held high until rd_ack seen.
REQ-007 rd_ack  output  1  One-cycle read acknowledge; registered.
REQ-008 rd_data  output  8  Snapshot of sticky status at read; registered; valid while rd_ack=1 and held until the next read.
REQ-009 rd_ovr  output  8  Snapshot of overrun flags at read; registered; same timing as rd_data.
REQ-010 irq  output  1  Interrupt = OR over (status & irq_en), derived from registered status.

Function
REQ-011 Internal regs: status[7:0], ovr[7:0], 2-bit FSM state {IDLE, SNAP, ACK, WAIT}.
REQ-012 Set rule, outside SNAP: status[i] <= 1 when evt[i]=1; otherwise status[i] holds.
REQ-013 Overrun rule, outside SNAP: ovr[i] <= 1 when evt[i]=1 and status[i] is already 1; otherwise ovr[i] holds.
REQ-014 IDLE: if rd_req=1 at edge k, go to SNAP; status/ovr follow REQ-012/013 at that same edge.
REQ-015 SNAP, edge k+1: rd_data <= status and rd_ovr <= ovr (pre-edge values); status <= evt; ovr <= 0; rd_ack <= 1; go to ACK.
REQ-016 Simultaneous set and clear in SNAP: the new event wins. The bit reads 1 afterward and is not flagged as overrun; no event is lost.
REQ-017 ACK, edge k+2: rd_ack <= 0; go to WAIT. rd_ack is high for exactly one cycle per read.
REQ-018 WAIT: stay while rd_req=1; go to IDLE on the first edge with rd_req=0. A held rd_req never triggers a second read.
REQ-019 Latency: rd_req sampled high in IDLE at edge k gives rd_ack high during the cycle after edge k+1. Minimum spacing between reads is 4 cycles.
REQ-020 Outside SNAP, rd_data and rd_ovr hold their last values.
REQ-021 REQ-012/013 keep operating in IDLE, ACK and WAIT.
REQ-022 irq is combinational from the registered status and irq_en. Changing irq_en takes effect in the same cycle.
REQ-023 All-zero evt and no rd_req leaves every register unchanged indefinitely.

Reset
REQ-024 rst=1 at an edge sets: status=0, ovr=0, rd_data=0, rd_ovr=0, rd_ack=0, state=IDLE. This is unconditional and overrides evt and rd_req in that cycle.
REQ-025 rst asserted mid-read (SNAP, ACK or WAIT) aborts the read: no rd_ack pulse follows, and state is IDLE after the edge.
REQ-026 After rst deasserts, if rd_req is still high, it is treated as a new request in IDLE.

Verification
REQ-027 Basic set/read:
- Stimulus: evt=8'h05 for 1 cycle, then rd_req=1.
- Response: rd_ack pulses once; rd_data=8'h05, rd_ovr=8'h00; status=0 afterward; irq=0 with irq_en=8'hFF.
REQ-028 Overrun:
- Stimulus: evt=8'h01 twice in separate cycles, then read.
- Response: rd_data=8'h01, rd_ovr=8'h01; the next read returns 8'h00/8'h00.
REQ-029 Set-during-clear:
- Stimulus: status=8'h02; evt=8'h02 exactly in the SNAP cycle.
- Response: rd_data=8'h02, rd_ovr=8'h00; status=8'h02 afterward; a second read returns rd_data=8'h02.
REQ-030 Held request:
- Stimulus: rd_req high for 10 cycles.
- Response: exactly one rd_ack pulse, 2 cycles after rd_req is first sampled; FSM stays in WAIT until rd_req=0.
REQ-031 irq masking:
- Stimulus: evt=8'h80 with irq_en=8'h7F, then irq_en=8'hFF.
- Response: irq=0, then irq=1 in the same cycle irq_en changes; after a read, irq=0.
REQ-032 Reset mid-read:
- Stimulus: rst=1 in the SNAP cycle, with status=8'hAA and evt=8'h01.
- Response: no rd_ack; all outputs 0; status=0 after the edge.
